// File: rtl/proc_control_fsm.sv
// Instruction sequencer: steps a captured 9-bit instruction through T0..T3 and drives register/ALU/bus strobes.
// Latency: accept edge is cycle 0; mv/mvi/illegal finish in cycle 1, add/sub in cycle 3.
// Backpressure: run is sampled only in T0; while busy, run is ignored and nothing is queued.
module proc_control_fsm #(
  parameter int NREG = 8,
  parameter int IR_W = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [IR_W-1:0] ir_data,
  output logic [NREG-1:0] r_in,
  output logic [NREG-1:0] r_out,
  output logic            imm_out,
  output logic            a_in,
  output logic            g_in,
  output logic            g_out,
  output logic            addsub,
  output logic            busy,
  output logic            done,
  output logic            illegal
);

  // Register-select field width; IR is [opcode(3) | Rx | Ry].
  localparam int RW = (IR_W - 3) / 2;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IR_W-1:0]   ir;
  logic [2:0]        opcode;
  logic [RW-1:0]     rx;
  logic [RW-1:0]     ry;
  logic [NREG-1:0]   rx_oh;
  logic [NREG-1:0]   ry_oh;

  assign opcode = ir[IR_W-1 -: 3];
  assign rx     = ir[2*RW-1 -: RW];
  assign ry     = ir[RW-1:0];
  assign rx_oh  = {{(NREG-1){1'b0}}, 1'b1} << rx;
  assign ry_oh  = {{(NREG-1){1'b0}}, 1'b1} << ry;

  // State register and instruction capture; IR only loads on an accept in T0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == T0 && run) begin
        ir <= ir_data;
      end
    end
  end

  // Next-state and strobe decode from state + IR; everything forced low while in reset.
  always_comb begin
    state_nxt = state;
    r_in      = '0;
    r_out     = '0;
    imm_out   = 1'b0;
    a_in      = 1'b0;
    g_in      = 1'b0;
    g_out     = 1'b0;
    addsub    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;

    case (state)
      T0: begin
        if (run) begin
          state_nxt = T1;
        end
      end
      T1: begin
        busy = 1'b1;
        case (opcode)
          OP_MV: begin
            r_out     = ry_oh;
            r_in      = rx_oh;
            done      = 1'b1;
            state_nxt = T0;
          end
          OP_MVI: begin
            imm_out   = 1'b1;
            r_in      = rx_oh;
            done      = 1'b1;
            state_nxt = T0;
          end
          OP_ADD, OP_SUB: begin
            // First operand Rx goes through the bus into A.
            r_out     = rx_oh;
            a_in      = 1'b1;
            state_nxt = T2;
          end
          default: begin
            illegal   = 1'b1;
            done      = 1'b1;
            state_nxt = T0;
          end
        endcase
      end
      T2: begin
        // Second operand Ry on the bus; G captures A +/- bus, opcode LSB picks sub.
        busy      = 1'b1;
        r_out     = ry_oh;
        g_in      = 1'b1;
        addsub    = ir[IR_W-3];
        state_nxt = T3;
      end
      T3: begin
        // Result in G written back to Rx.
        busy      = 1'b1;
        g_out     = 1'b1;
        r_in      = rx_oh;
        done      = 1'b1;
        state_nxt = T0;
      end
      default: begin
        state_nxt = T0;
      end
    endcase

    if (!rst) begin
      r_in    = '0;
      r_out   = '0;
      imm_out = 1'b0;
      a_in    = 1'b0;
      g_in    = 1'b0;
      g_out   = 1'b0;
      addsub  = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Bench for proc_control_fsm: scoreboard of per-cycle expected output vectors.
// Each cycle: drive at negedge, sample #1 later, pop and compare.
// Expectations are built from the instruction encoding, independent of the DUT.
module tb_proc_control_fsm;

  logic       clk;
  logic       rst;
  logic       run;
  logic [8:0] ir_data;
  logic [7:0] r_in;
  logic [7:0] r_out;
  logic       imm_out, a_in, g_in, g_out, addsub, busy, done, illegal;

  logic [23:0] obs;
  logic [23:0] exp_q[$];
  int checks;
  int errors;

  proc_control_fsm #(.NREG(8), .IR_W(9)) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .ir_data (ir_data),
    .r_in    (r_in),
    .r_out   (r_out),
    .imm_out (imm_out),
    .a_in    (a_in),
    .g_in    (g_in),
    .g_out   (g_out),
    .addsub  (addsub),
    .busy    (busy),
    .done    (done),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {r_in, r_out, imm_out, a_in, g_in, g_out, addsub, busy, done, illegal};

  function automatic logic [23:0] mk(input logic [7:0] ri, input logic [7:0] ro,
                                     input logic imm, input logic a, input logic gi,
                                     input logic go, input logic as, input logic b,
                                     input logic d, input logic il);
    return {ri, ro, imm, a, gi, go, as, b, d, il};
  endfunction

  // Push the expected per-cycle vectors (T1 onward) for one accepted instruction.
  task automatic push_instr(input logic [8:0] i);
    logic [7:0] one;
    logic [7:0] ohx;
    logic [7:0] ohy;
    one = 8'h01;
    ohx = one << i[5:3];
    ohy = one << i[2:0];
    case (i[8:6])
      3'b000: exp_q.push_back(mk(ohx, ohy, 0, 0, 0, 0, 0, 1, 1, 0));
      3'b001: exp_q.push_back(mk(ohx, 8'h00, 1, 0, 0, 0, 0, 1, 1, 0));
      3'b010, 3'b011: begin
        exp_q.push_back(mk(8'h00, ohx, 0, 1, 0, 0, 0, 1, 0, 0));
        exp_q.push_back(mk(8'h00, ohy, 0, 0, 1, 0, i[6], 1, 0, 0));
        exp_q.push_back(mk(ohx, 8'h00, 0, 0, 0, 1, 0, 1, 1, 0));
      end
      default: exp_q.push_back(mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1));
    endcase
  endtask

  task automatic test_reset;
    rst = 1'b0;
    run = 1'b1;
    ir_data = 9'b010_001_010;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (obs !== 24'h0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d got %h want %h", c, obs, 24'h0);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    #1;
    checks++;
    if (obs !== 24'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got %h want %h", obs, 24'h0);
    end
  endtask

  task automatic test_mv;
    logic [8:0] list[2];
    logic [23:0] e;
    list[0] = 9'b000_011_101;
    list[1] = 9'b000_100_100;
    foreach (list[n]) begin
      @(negedge clk);
      run = 1'b1;
      ir_data = list[n];
      #1;
      checks++;
      if (obs !== 24'h0) begin
        errors++;
        $display("FAIL mv_accept%0d got %h want %h", n, obs, 24'h0);
      end
      push_instr(list[n]);
      while (exp_q.size() > 0) begin
        @(negedge clk);
        run = 1'b0;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL mv_step%0d got %h want %h", n, obs, e);
        end
      end
      @(negedge clk);
      #1;
      checks++;
      if (obs !== 24'h0) begin
        errors++;
        $display("FAIL mv_idle%0d got %h want %h", n, obs, 24'h0);
      end
    end
  endtask

  task automatic test_sub;
    logic [23:0] e;
    int step;
    @(negedge clk);
    run = 1'b1;
    ir_data = 9'b011_001_010;
    #1;
    push_instr(ir_data);
    step = 1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      run = 1'b0;
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL sub_T%0d got %h want %h", step, obs, e);
      end
      step++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (obs !== 24'h0) begin
      errors++;
      $display("FAIL sub_idle got %h want %h", obs, 24'h0);
    end
  endtask

  task automatic test_illegal_mvi;
    logic [23:0] e;
    @(negedge clk);
    run = 1'b1;
    ir_data = 9'b110_000_000;
    #1;
    push_instr(ir_data);
    exp_q.push_back(24'h0);
    push_instr(9'b001_111_000);
    exp_q.push_back(24'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      run = (c == 2);
      ir_data = (c == 2) ? 9'b001_111_000 : 9'b110_000_000;
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL illegal_mvi cyc%0d got %h want %h", c, obs, e);
      end
    end
    run = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [23:0] e;
    int dones;
    int rise[$];
    logic prev_busy;
    int bus_drv;
    dones = 0;
    prev_busy = 1'b0;
    ir_data = 9'b010_000_000;
    exp_q.push_back(24'h0);
    push_instr(ir_data);
    exp_q.push_back(24'h0);
    push_instr(ir_data);
    exp_q.push_back(24'h0);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      run = (c < 6);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL b2b cyc%0d got %h want %h", c, obs, e);
      end
      bus_drv = $countones(r_out) + int'(imm_out) + int'(g_out);
      checks++;
      if (bus_drv > 1) begin
        errors++;
        $display("FAIL bus_excl cyc%0d got %0d drivers want <=1", c, bus_drv);
      end
      if (done === 1'b1) dones++;
      if (busy === 1'b1 && prev_busy === 1'b0) rise.push_back(c);
      prev_busy = busy;
    end
    checks++;
    if (dones != 2) begin
      errors++;
      $display("FAIL b2b_done_count got %0d want 2", dones);
    end
    checks++;
    if (rise.size() != 2 || (rise[1] - rise[0]) != 4) begin
      errors++;
      $display("FAIL b2b_spacing got %0d starts want 2 starts 4 apart", rise.size());
    end
  endtask

  task automatic test_reset_mid;
    logic [23:0] e;
    @(negedge clk);
    run = 1'b1;
    ir_data = 9'b010_010_011;
    #1;
    push_instr(ir_data);
    @(negedge clk);
    run = 1'b0;
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL rstmid_T1 got %h want %h", obs, e);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== 24'h0) begin
      errors++;
      $display("FAIL rstmid_T2 got %h want %h", obs, 24'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    run = 1'b1;
    ir_data = 9'b000_110_001;
    #1;
    checks++;
    if (obs !== 24'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after got %h want %h", obs, 24'h0);
    end
    push_instr(ir_data);
    @(negedge clk);
    run = 1'b0;
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL rstmid_next got %h want %h", obs, e);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    run     = 1'b0;
    ir_data = '0;
    test_reset();
    test_mv();
    test_sub();
    test_illegal_mvi();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
